// File: rtl/ow_master.sv
// ow_master: 1-Wire bus initiator (reset/presence, write byte, read byte), standard-speed slots.
// All timing derives from a microsecond tick; bits travel LSB first.
// Optional feature: define OW_CRC8_EN to add crc8/crc_ok outputs, a Dallas CRC-8 over every bus bit.
module ow_master #(
  parameter int unsigned CLK_PER_US = 50,
  parameter int unsigned T_RSTL     = 480,
  parameter int unsigned T_PDS      = 70,
  parameter int unsigned T_RSTH     = 480,
  parameter int unsigned T_LOW1     = 6,
  parameter int unsigned T_LOW0     = 60,
  parameter int unsigned T_RDS      = 15,
  parameter int unsigned T_SLOT     = 70
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       presence,
  input  logic       dq_in,
  output logic       dq_out,
`ifdef OW_CRC8_EN
  output logic       dq_ena,
  output logic [7:0] crc8,
  output logic       crc_ok
`else
  output logic       dq_ena
`endif
);

  localparam int unsigned PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RST_LOW, S_RST_HIGH, S_BIT_LOW, S_BIT_REL, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_RESET = 2'b00, OP_WRITE = 2'b01, OP_READ = 2'b10, OP_NOP = 2'b11
  } op_e;

  state_e          state_q, state_d;
  op_e             op_q;
  logic [PW-1:0]   pre;
  logic [9:0]      us_cnt;
  logic            us_tick;
  logic [7:0]      shreg;
  logic [2:0]      bit_cnt;
  logic            dq_meta, dq_sync;
  logic            accept, pres_pt, sample_pt, slot_end;
  int unsigned     low_us;

  // True on the tick that completes microsecond n of the current phase
  function automatic logic reached(input logic tick, input logic [9:0] cnt, input int unsigned n);
    return tick && (cnt == 10'(n - 1));
  endfunction

  assign us_tick = (pre == PW'(CLK_PER_US - 1));
  // Write slots shift only at slot end, so shreg[0] is the bit of the slot in progress
  assign low_us  = (op_q == OP_WRITE && !shreg[0]) ? T_LOW0 : T_LOW1;

  // Two-flop synchronizer for the bus input
  always_ff @(posedge clk) begin
    if (rst) begin
      dq_meta <= 1'b1;
      dq_sync <= 1'b1;
    end else begin
      dq_meta <= dq_in;
      dq_sync <= dq_meta;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic, bus drive and handshake outputs
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    dq_ena    = 1'b0;
    dq_out    = 1'b1;
    accept    = 1'b0;
    pres_pt   = 1'b0;
    sample_pt = 1'b0;
    slot_end  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept = 1'b1;
          case (op_e'(cmd_op))
            OP_RESET: state_d = S_RST_LOW;
            OP_WRITE,
            OP_READ:  state_d = S_BIT_LOW;
            default:  state_d = S_DONE;
          endcase
        end
      end
      S_RST_LOW: begin
        dq_ena = 1'b1;
        dq_out = 1'b0;
        if (reached(us_tick, us_cnt, T_RSTL)) state_d = S_RST_HIGH;
      end
      S_RST_HIGH: begin
        pres_pt = reached(us_tick, us_cnt, T_PDS);
        if (reached(us_tick, us_cnt, T_RSTH)) state_d = S_DONE;
      end
      S_BIT_LOW: begin
        dq_ena = 1'b1;
        dq_out = 1'b0;
        if (reached(us_tick, us_cnt, low_us)) state_d = S_BIT_REL;
      end
      S_BIT_REL: begin
        // Counter restarted at release, so slot-relative times are offset by the low time
        sample_pt = (op_q == OP_READ) && reached(us_tick, us_cnt, T_RDS - T_LOW1);
        if (reached(us_tick, us_cnt, T_SLOT - low_us)) begin
          slot_end = 1'b1;
          state_d  = (bit_cnt == 3'd7) ? S_DONE : S_BIT_LOW;
        end
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Timebase, command capture, bit shifting and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pre      <= '0;
      us_cnt   <= '0;
      op_q     <= OP_NOP;
      shreg    <= '0;
      bit_cnt  <= '0;
      presence <= 1'b0;
      rsp_data <= '0;
    end else begin
      if (state_d != state_q) begin
        pre    <= '0;
        us_cnt <= '0;
      end else if (us_tick) begin
        pre    <= '0;
        us_cnt <= us_cnt + 10'd1;
      end else begin
        pre <= pre + PW'(1);
      end

      if (accept) begin
        op_q    <= op_e'(cmd_op);
        shreg   <= cmd_data;
        bit_cnt <= '0;
      end else if (sample_pt) begin
        shreg <= {dq_sync, shreg[7:1]};
      end else if (slot_end) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (op_q == OP_WRITE) shreg <= {1'b0, shreg[7:1]};
      end

      if (pres_pt) presence <= !dq_sync;

      if (state_d == S_DONE && state_q != S_DONE)
        rsp_data <= (state_q == S_BIT_REL && op_q == OP_READ) ? shreg : '0;
    end
  end

`ifdef OW_CRC8_EN
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    return {1'b0, c[7:1]} ^ ((c[0] ^ b) ? 8'h8C : 8'h00);
  endfunction

  // CRC-8 over every bit written or read; a reset op starts a fresh ROM sequence
  always_ff @(posedge clk) begin
    if (rst)                                          crc8 <= '0;
    else if (accept && op_e'(cmd_op) == OP_RESET)     crc8 <= '0;
    else if (sample_pt)                               crc8 <= crc_step(crc8, dq_sync);
    else if (slot_end && op_q == OP_WRITE)            crc8 <= crc_step(crc8, shreg[0]);
  end

  assign crc_ok = (crc8 == 8'h00);
`endif

endmodule

// File: tb/tb_ow_master.sv
// tb_ow_master: randomized self-checking bench for ow_master with a behavioural 1-Wire slave.
// Build with OW_CRC8_EN defined to include the CRC scenario.
module tb_ow_master;
  localparam int unsigned C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       presence;
  logic       dq_in;
  logic       dq_out;
  logic       dq_ena;
`ifdef OW_CRC8_EN
  logic [7:0] crc8;
  logic       crc_ok;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  bit          exp_presence = 1'b0;

  always #5 clk = ~clk;

  ow_master #(.CLK_PER_US(C)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .presence(presence), .dq_in(dq_in), .dq_out(dq_out),
`ifdef OW_CRC8_EN
    .dq_ena(dq_ena), .crc8(crc8), .crc_ok(crc_ok)
`else
    .dq_ena(dq_ena)
`endif
  );

  // Open-drain bus: low if the master or the slave pulls it
  logic slave_low = 1'b0;
  assign dq_in = ~(dq_ena & ~dq_out) & ~slave_low;

  // Bus monitor and slave: records master low pulses (in clk) and their start times
  int unsigned cyc = 0, run = 0;
  bit          prev_low = 1'b0;
  int unsigned lows[$];
  int unsigned starts[$];
  int unsigned slave_mode = 0;   // 0 absent, 1 presence responder, 2 read responder
  logic [7:0]  slave_byte = 8'h00;
  int unsigned sbit = 0, slave_until = 0, ps = 0, pe = 0;

  always @(negedge clk) begin
    logic mlow;
    cyc++;
    mlow = dq_ena & ~dq_out;
    if (mlow && !prev_low) begin
      starts.push_back(cyc);
      run = 0;
      if (slave_mode == 2) begin
        if (!slave_byte[sbit[2:0]]) slave_until = cyc + 30 * C;
        sbit++;
      end
    end
    if (mlow) run++;
    if (!mlow && prev_low) begin
      lows.push_back(run);
      if (slave_mode == 1 && run >= 400 * C) begin
        ps = cyc + 20 * C;
        pe = ps + $urandom_range(200, 80) * C;
      end
    end
    prev_low  = mlow;
    slave_low = (cyc < slave_until) || (cyc >= ps && cyc < pe);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] data);
    int unsigned k = 0;
    @(negedge clk);
    cmd_op = op; cmd_data = data; cmd_valid = 1'b1;
    while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept: cmd_ready=%0b required 1", cmd_ready);
    end
  endtask

  // lat = number of falling edges after the accepting edge until rsp_valid is seen
  task automatic wait_rsp(input int unsigned budget, output bit got, output int unsigned lat);
    got = 1'b0; lat = 0;
    for (int unsigned i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (i == 1) begin cmd_valid = 1'b0; cmd_data = 8'($urandom); cmd_op = 2'($urandom); end
      if (rsp_valid === 1'b1) begin got = 1'b1; lat = i; break; end
    end
  endtask

  // Reference: count slots whose low pulse differs from the byte's LSB-first pattern
  function automatic int unsigned pat_err(input logic [7:0] d, input bit rd);
    int unsigned e = (lows.size() == 8) ? 0 : 1;
    for (int unsigned i = 0; i < 8 && i < lows.size(); i++)
      if (lows[i] != ((rd || d[i]) ? 6 * C : 60 * C)) e++;
    for (int unsigned i = 1; i < 8 && i < starts.size(); i++)
      if (starts[i] - starts[i-1] != 70 * C) e++;
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cmd_ready, rsp_valid, rsp_data, presence, dq_ena, dq_out} !== 13'b1_0_00000000_0_0_1) begin
      n_fail++;
      $display("FAIL reset_values: got %b required 1_0_00000000_0_0_1",
               {cmd_ready, rsp_valid, rsp_data, presence, dq_ena, dq_out});
    end
    rst = 1'b0;
    exp_presence = 1'b0;
  endtask

  task automatic test_presence(input bit slave);
    bit got; int unsigned lat, l0;
    slave_mode = slave ? 1 : 0; ps = 0; pe = 0;
    lows.delete(); starts.delete();
    issue(2'b00, 8'($urandom));
    wait_rsp(5000, got, lat);
    n_checks++;
    if (!got || lat < 960 * C || lat > 960 * C + 8) begin
      n_fail++; $display("FAIL reset_latency: got=%0b lat=%0d required ~%0d", got, lat, 960 * C + 1);
    end
    l0 = (lows.size() == 1) ? lows[0] : 0;
    n_checks++;
    if (l0 != 480 * C) begin
      n_fail++; $display("FAIL reset_low: %0d clk (pulses %0d) required %0d", l0, lows.size(), 480 * C);
    end
    n_checks++;
    if (presence !== slave || rsp_data !== 8'h00) begin
      n_fail++; $display("FAIL presence: presence=%0b rsp_data=%h required %0b/00", presence, rsp_data, slave);
    end
    exp_presence = slave;
    slave_mode = 0;
  endtask

  task automatic test_write(input logic [7:0] d);
    bit got; int unsigned lat, e;
    lows.delete(); starts.delete();
    issue(2'b01, d);
    wait_rsp(3000, got, lat);
    n_checks++;
    if (!got || lat != 560 * C + 1) begin
      n_fail++; $display("FAIL write_latency: got=%0b lat=%0d required %0d", got, lat, 560 * C + 1);
    end
    e = pat_err(d, 1'b0);
    n_checks++;
    if (e != 0) begin
      n_fail++; $display("FAIL write_slots %h: %0d slot errors required 0", d, e);
    end
    n_checks++;
    if (rsp_data !== 8'h00 || presence !== exp_presence) begin
      n_fail++; $display("FAIL write_rsp: rsp_data=%h presence=%0b required 00/%0b", rsp_data, presence, exp_presence);
    end
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_fail++; $display("FAIL write_after: rsp_valid,cmd_ready=%b required 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_read(input logic [7:0] d);
    bit got; int unsigned lat, e;
    lows.delete(); starts.delete();
    slave_mode = 2; slave_byte = d; sbit = 0; slave_until = 0;
    issue(2'b10, 8'($urandom));
    wait_rsp(3000, got, lat);
    n_checks++;
    if (!got || rsp_data !== d) begin
      n_fail++; $display("FAIL read_data: got=%0b rsp_data=%h required %h", got, rsp_data, d);
    end
    e = pat_err(d, 1'b1);
    n_checks++;
    if (e != 0 || lat != 560 * C + 1) begin
      n_fail++; $display("FAIL read_slots: %0d slot errors, lat=%0d required 0/%0d", e, lat, 560 * C + 1);
    end
    slave_mode = 0;
  endtask

  task automatic test_nop();
    bit got; int unsigned lat;
    lows.delete(); starts.delete();
    issue(2'b11, 8'($urandom));
    wait_rsp(10, got, lat);
    n_checks++;
    if (!got || lat != 1 || rsp_data !== 8'h00 || lows.size() != 0 || presence !== exp_presence) begin
      n_fail++;
      $display("FAIL nop: got=%0b lat=%0d rsp_data=%h pulses=%0d presence=%0b required 1/1/00/0/%0b",
               got, lat, rsp_data, lows.size(), presence, exp_presence);
    end
  endtask

  task automatic test_rst_abort();
    int unsigned k = 0, bad = 0;
    lows.delete(); starts.delete();
    issue(2'b01, 8'($urandom) & 8'hF7);
    @(negedge clk); cmd_valid = 1'b0;
    while (starts.size() < 4 && k < 1500) begin @(negedge clk); k++; end
    repeat (10) @(negedge clk);
    n_checks++;
    if (starts.size() != 4 || dq_ena !== 1'b1) begin
      n_fail++; $display("FAIL abort_setup: slots=%0d dq_ena=%0b required 4/1", starts.size(), dq_ena);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({dq_ena, cmd_ready, rsp_valid} !== 3'b010) begin
      n_fail++; $display("FAIL abort_release: dq_ena,cmd_ready,rsp_valid=%b required 010", {dq_ena, cmd_ready, rsp_valid});
    end
    rst = 1'b0;
    exp_presence = 1'b0;
    repeat (400) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || dq_ena !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0 || presence !== 1'b0) begin
      n_fail++; $display("FAIL abort_quiet: %0d active cycles presence=%0b required 0/0", bad, presence);
    end
  endtask

  task automatic test_back_to_back(input logic [7:0] d1, input logic [7:0] d2);
    bit got = 1'b0; int unsigned seen_ready = 0, lat, e;
    lows.delete(); starts.delete();
    issue(2'b01, d1);
    for (int unsigned i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (i == 1) cmd_data = d2;
      if (rsp_valid === 1'b1) begin got = 1'b1; break; end
      if (cmd_ready !== 1'b0) seen_ready++;
    end
    e = pat_err(d1, 1'b0);
    n_checks++;
    if (!got || seen_ready != 0 || e != 0) begin
      n_fail++; $display("FAIL b2b_first %h: got=%0b ready_cycles=%0d slot_errors=%0d required 1/0/0", d1, got, seen_ready, e);
    end
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready: cmd_ready=%0b required 1", cmd_ready);
    end
    lows.delete(); starts.delete();
    wait_rsp(3000, got, lat);
    e = pat_err(d2, 1'b0);
    n_checks++;
    if (!got || lat != 560 * C + 1 || e != 0) begin
      n_fail++; $display("FAIL b2b_second %h: got=%0b lat=%0d slot_errors=%0d required 1/%0d/0", d2, got, lat, e, 560 * C + 1);
    end
  endtask

`ifdef OW_CRC8_EN
  function automatic logic [7:0] crc_model(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r = c;
    for (int unsigned i = 0; i < 8; i++)
      r = (r >> 1) ^ (((r[0] ^ d[i]) != 1'b0) ? 8'h8C : 8'h00);
    return r;
  endfunction

  task automatic test_crc();
    logic [7:0] rom [7];
    logic [7:0] mc, rb;
    bit got; int unsigned lat;
    for (int unsigned pass = 0; pass < 2; pass++) begin
      test_presence(1'b1);
      mc = 8'h00;
      for (int unsigned i = 0; i < 7; i++) begin
        rom[i] = (i == 0) ? 8'h28 : 8'($urandom);
        issue(2'b01, rom[i]);
        wait_rsp(3000, got, lat);
        mc = crc_model(mc, rom[i]);
      end
      n_checks++;
      if (crc8 !== mc) begin
        n_fail++; $display("FAIL crc_value: crc8=%h required %h", crc8, mc);
      end
      rb = (pass == 0) ? mc : (mc ^ (8'h01 << $urandom_range(7, 0)));
      slave_mode = 2; slave_byte = rb; sbit = 0; slave_until = 0;
      issue(2'b10, 8'h00);
      wait_rsp(3000, got, lat);
      slave_mode = 0;
      n_checks++;
      if (!got || rsp_data !== rb || crc_ok !== (pass == 0)) begin
        n_fail++; $display("FAIL crc_ok pass%0d: crc_ok=%0b rsp_data=%h required %0b/%h", pass, crc_ok, rsp_data, pass == 0, rb);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_presence(1'b1);
    test_presence(1'b0);
    test_write(8'hA5);
    test_presence(1'b1);
    test_write(8'($urandom));
    test_nop();
    test_read(8'h3C);
    test_read(8'($urandom));
    test_read(8'($urandom));
    test_write(8'($urandom));
    test_back_to_back(8'($urandom), 8'($urandom));
    test_rst_abort();
`ifdef OW_CRC8_EN
    test_crc();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
